// File: rtl/dual_port_mem_arbiter.sv
// Purpose : shares NBANKS synchronous-read banks between a CPU port (rd/wr) and a VGA scan-out port (rd only).
// Latency : grant is combinational, access issues in the grant cycle, read data returns RD_LAT cycles later.
// Backpr. : a port holds its request until gnt; ARB_STARVE_EN adds a CPU starvation guard (MAX_WAIT cycles).
module dual_port_mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int NBANKS   = 3,
    parameter int RD_LAT   = 1,
    parameter int MODE     = 0,
    parameter int MAX_WAIT = 15,
    localparam int BW      = $clog2(NBANKS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vga_en,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic                 cpu_gnt,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_rvalid,
    input  logic                 vga_req,
    input  logic [AW-1:0]        vga_addr,
    output logic                 vga_gnt,
    output logic [DW-1:0]        vga_rdata,
    output logic                 vga_rvalid,
    output logic [AW-BW-1:0]     mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic [NBANKS-1:0]    mem_we,
    input  logic [NBANKS*DW-1:0] mem_rdata,
    output logic                 bad_addr
);

    localparam int          MW      = AW - BW;
    localparam logic        OWN_CPU = 1'b0;
    localparam logic        OWN_VGA = 1'b1;
    localparam logic [BW:0] NB_LIM  = (BW+1)'(NBANKS);

    // ------------------------------------------------------------------
    // Reset: assertion is immediate, release is retimed through two flops
    // so every state flop leaves reset on the same clean edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    // Two-flop release synchroniser for the asynchronous reset input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic cpu_elig;
    logic vga_elig;
    logic conflict;
    logic last_win;       // owner that won the most recent conflict
    logic starve_force;   // CPU has waited long enough to bypass MODE

    // Nothing is granted while the synchronised reset is still active
    assign cpu_elig = cpu_req && rst_n;
    assign vga_elig = vga_req && vga_en && rst_n;
    assign conflict = cpu_elig && vga_elig;

`ifdef ARB_STARVE_EN
    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    assign starve_force = (wait_cnt == WAIT_LIM);

    // Count consecutive refused CPU cycles, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // Without the guard MAX_WAIT has no effect; the CPU may starve under MODE 0.
    logic unused_wait;
    assign unused_wait  = ^MAX_WAIT;
    assign starve_force = 1'b0;
`endif

    // Single-winner grant: lone requester wins, conflicts resolved by MODE
    always_comb begin
        cpu_gnt = 1'b0;
        vga_gnt = 1'b0;
        if (conflict) begin
            if (starve_force) begin
                cpu_gnt = 1'b1;
            end else if (MODE == 0) begin
                vga_gnt = 1'b1;
            end else if (last_win == OWN_VGA) begin
                cpu_gnt = 1'b1;
            end else begin
                vga_gnt = 1'b1;
            end
        end else begin
            cpu_gnt = cpu_elig;
            vga_gnt = vga_elig;
        end
    end

    // Remember the conflict winner so round-robin alternates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= OWN_CPU;
        end else if (conflict) begin
            last_win <= vga_gnt ? OWN_VGA : OWN_CPU;
        end
    end

    // ------------------------------------------------------------------
    // Issue path: bank decode from the top address bits
    // ------------------------------------------------------------------
    logic          issue;
    logic          iss_we;
    logic [AW-1:0] iss_addr;
    logic [BW-1:0] iss_bank;
    logic          iss_bad;
    logic          push_rd;
    logic [MW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    assign issue    = cpu_gnt || vga_gnt;
    assign iss_we   = cpu_gnt && cpu_we;
    assign iss_addr = cpu_gnt ? cpu_addr : vga_addr;
    assign iss_bank = iss_addr[AW-1 -: BW];
    assign iss_bad  = ({1'b0, iss_bank} >= NB_LIM);
    assign push_rd  = issue && !iss_we;

    // Shared bank address/data follow the granted port, otherwise hold
    assign mem_addr  = issue  ? iss_addr[MW-1:0] : addr_q;
    assign mem_wdata = iss_we ? cpu_wdata        : wdata_q;

    // One-hot write strobe; writes to a non-existent bank are dropped
    always_comb begin
        mem_we = '0;
        for (int k = 0; k < NBANKS; k++) begin
            mem_we[k] = iss_we && !iss_bad && (iss_bank == BW'(k));
        end
    end

    // Hold registers for the shared bus and the sticky bad-bank flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            bad_addr <= 1'b0;
        end else begin
            if (issue) begin
                addr_q <= iss_addr[MW-1:0];
            end
            if (iss_we) begin
                wdata_q <= cpu_wdata;
            end
            if (issue && iss_bad) begin
                bad_addr <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-return pipeline: one slot per cycle of bank latency, so reads
    // can issue every cycle and return in grant order.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_own;
    logic [RD_LAT-1:0] pipe_bad;
    logic [BW-1:0]     pipe_bank [RD_LAT];

    // Shift read tags alongside the bank latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_own <= '0;
            pipe_bad <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_bank[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= push_rd;
            pipe_own[0]  <= vga_gnt ? OWN_VGA : OWN_CPU;
            pipe_bad[0]  <= iss_bad;
            pipe_bank[0] <= iss_bank;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_own[i]  <= pipe_own[i-1];
                pipe_bad[i]  <= pipe_bad[i-1];
                pipe_bank[i] <= pipe_bank[i-1];
            end
        end
    end

    logic          ret_vld;
    logic          ret_own;
    logic          ret_bad;
    logic [BW-1:0] ret_bank;
    logic [DW-1:0] ret_data;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] vga_rdata_q;

    assign ret_vld  = pipe_vld[RD_LAT-1];
    assign ret_own  = pipe_own[RD_LAT-1];
    assign ret_bad  = pipe_bad[RD_LAT-1];
    assign ret_bank = pipe_bank[RD_LAT-1];

    // Pick the returning bank's data; a bad bank reads as zero
    always_comb begin
        ret_data = '0;
        for (int k = 0; k < NBANKS; k++) begin
            if (!ret_bad && (ret_bank == BW'(k))) begin
                ret_data = mem_rdata[k*DW +: DW];
            end
        end
    end

    assign cpu_rvalid = ret_vld && (ret_own == OWN_CPU);
    assign vga_rvalid = ret_vld && (ret_own == OWN_VGA);
    assign cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_q;
    assign vga_rdata  = vga_rvalid ? ret_data : vga_rdata_q;

    // Keep the last returned word per port so rdata is stable between returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= ret_data;
            end
            if (vga_rvalid) begin
                vga_rdata_q <= ret_data;
            end
        end
    end

endmodule
